imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the RV decode pipeline. It sits between fetch and the register-read/execute stage and accepts one 32-bit instruction plus its PC per valid/ready handshake. For each instruction it emits the sign- or zero-extended immediate, an immediate-type tag, an illegal flag and a precomputed PC-relative target. A two-entry skid buffer gives full throughput with a registered `in_ready_o`, and a flush input clears the stage synchronously.

---
 rtl/imm_gen_stage_pkg.sv | 40 ++++
 rtl/imm_gen_stage_if.sv | 33 +++
 rtl/imm_gen_stage_decode.sv | 98 +++++++++
 rtl/imm_gen_stage.sv | 110 +++++++++++
 tb/tb_imm_gen_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage.
//   imm_type_e : tag reported with every decoded immediate
//   OPC_*      : major opcodes the decoder recognises
//   sext       : sign-extends the low 'width' bits of a 32-bit field to 64 bits
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSRZ  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_ITY    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_I64TY  = 7'h1b;
    localparam logic [6:0] OPC_ENV    = 7'h73;
    localparam logic [6:0] OPC_RTY    = 7'h33;
    localparam logic [6:0] OPC_R64TY  = 7'h3b;

    // Shift the field up to bit 31, then arithmetic-shift back down so the
    // field's top bit fills everything above it.
    function automatic logic [63:0] sext(input logic [31:0] val, input int unsigned width);
        logic signed [31:0] t;
        t = $signed(val << (32 - width));
        t = t >>> (32 - width);
        return {{32{t[31]}}, t};
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage.
//   Input side : in_valid_i, in_ready_o, inst_i, pc_i
//   Output side: out_valid_o, out_ready_i, imme_o, imm_type_o, illegal_o,
//                target_o, pc_o
// 'slave' is the stage's view; 'master' is the surrounding pipeline's view
// (producer of instructions and consumer of results).
interface imm_gen_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] imme_o;
    imm_type_e       imm_type_o;
    logic            illegal_o;
    logic [XLEN-1:0] target_o;
    logic [XLEN-1:0] pc_o;

    modport slave (
        input  in_valid_i, inst_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, imme_o, imm_type_o, illegal_o, target_o, pc_o
    );

    modport master (
        output in_valid_i, inst_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, imme_o, imm_type_o, illegal_o, target_o, pc_o
    );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder.
//   inst     : 32-bit instruction word
//   pc       : instruction PC
//   imm      : extended immediate
//   imm_type : immediate-type tag
//   illegal  : encoding not legal for this XLEN
//   target   : pc + imm for branches, JAL and AUIPC, otherwise 0
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal,
    output logic [XLEN-1:0] target
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;
    logic       use_target;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        imm        = '0;
        imm_type   = IMM_NONE;
        illegal    = 1'b0;
        use_target = 1'b0;
        case (opcode)
            OPC_ITY: begin
                if (is_shift) begin
                    // A 6-bit shift amount only exists on RV64.
                    imm_type = IMM_SHAMT;
                    imm      = XLEN'(inst[25:20]);
                    illegal  = (XLEN == 32) && inst[25];
                end else begin
                    imm_type = IMM_I;
                    imm      = XLEN'(sext({20'b0, inst[31:20]}, 12));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                imm      = XLEN'(sext({20'b0, inst[31:20]}, 12));
            end
            OPC_I64TY: begin
                // Word ops do not exist on RV32; leave imm/type cleared.
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    imm_type = IMM_SHAMT;
                    imm      = XLEN'(inst[24:20]);
                end else begin
                    imm_type = IMM_I;
                    imm      = XLEN'(sext({20'b0, inst[31:20]}, 12));
                end
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm      = XLEN'(sext({20'b0, inst[31:25], inst[11:7]}, 12));
            end
            OPC_BRANCH: begin
                imm_type   = IMM_B;
                imm        = XLEN'(sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13));
                use_target = 1'b1;
            end
            OPC_JAL: begin
                imm_type   = IMM_J;
                imm        = XLEN'(sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21));
                use_target = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type   = IMM_U;
                imm        = XLEN'(sext({inst[31:12], 12'b0}, 32));
                use_target = (opcode == OPC_AUIPC);
            end
            OPC_ENV: begin
                if (funct3[2]) begin
                    imm_type = IMM_CSRZ;
                    imm      = XLEN'(inst[19:15]);
                end
            end
            OPC_RTY, OPC_R64TY: begin
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign target = use_target ? (pc + imm) : '0;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer.
//   clk, rst : clock and synchronous active-high reset
//   flush_i  : drops both buffered entries and the same-cycle input
//   bus      : imm_gen_stage_if slave (instruction in, decoded result out)
// Decoding happens before the registers, so an accepted instruction appears
// at the output on the next cycle. in_ready_o depends only on registered
// state (and reset), never on out_ready_i.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    imm_gen_stage_if.slave        bus
);

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_target;

    logic            main_valid;
    logic [XLEN-1:0] main_imm;
    imm_type_e       main_type;
    logic            main_illegal;
    logic [XLEN-1:0] main_target;
    logic [XLEN-1:0] main_pc;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    imm_type_e       skid_type;
    logic            skid_illegal;
    logic [XLEN-1:0] skid_target;
    logic [XLEN-1:0] skid_pc;

    logic accept;
    logic xfer;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst     (bus.inst_i),
        .pc       (bus.pc_i),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal),
        .target   (dec_target)
    );

    assign bus.in_ready_o  = !rst && !skid_valid;
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign xfer            = main_valid && bus.out_ready_i;

    assign bus.out_valid_o = main_valid;
    assign bus.imme_o      = main_imm;
    assign bus.imm_type_o  = main_type;
    assign bus.illegal_o   = main_illegal;
    assign bus.target_o    = main_target;
    assign bus.pc_o        = main_pc;

    // Main is refilled whenever it is free this cycle, from skid first so
    // order is preserved. Accepting input while skid is full cannot happen
    // because in_ready_o is low then. Flush only drops the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            main_imm     <= '0;
            main_type    <= IMM_NONE;
            main_illegal <= 1'b0;
            main_target  <= '0;
            main_pc      <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
            skid_illegal <= 1'b0;
            skid_target  <= '0;
            skid_pc      <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (xfer || !main_valid) begin
            if (skid_valid) begin
                main_valid   <= 1'b1;
                main_imm     <= skid_imm;
                main_type    <= skid_type;
                main_illegal <= skid_illegal;
                main_target  <= skid_target;
                main_pc      <= skid_pc;
                skid_valid   <= 1'b0;
            end else if (accept) begin
                main_valid   <= 1'b1;
                main_imm     <= dec_imm;
                main_type    <= dec_type;
                main_illegal <= dec_illegal;
                main_target  <= dec_target;
                main_pc      <= bus.pc_i;
            end else begin
                main_valid   <= 1'b0;
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
            skid_target  <= dec_target;
            skid_pc      <= bus.pc_i;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed testbench for imm_gen_stage. A 64-bit stage carries most of the
// traffic; a 32-bit stage checks the RV32-only illegal encodings.
module tb_imm_gen_stage;
    import imm_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    logic flush32;
    int   tests_run;
    int   tests_failed;

    imm_gen_stage_if #(.XLEN(64)) bus64 ();
    imm_gen_stage_if #(.XLEN(32)) bus32 ();

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus64)
    );

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush32),
        .bus     (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive64(input logic [31:0] inst, input logic [63:0] pc);
        bus64.in_valid_i = 1'b1;
        bus64.inst_i     = inst;
        bus64.pc_i       = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++; if (bus64.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b want 0", bus64.out_valid_o); end
        tests_run++; if (bus64.in_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 0", bus64.in_ready_o); end
        tests_run++; if (bus64.imme_o !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_imm: got %h want 0", bus64.imme_o); end
        tests_run++; if (bus64.imm_type_o !== IMM_NONE) begin tests_failed++; $display("[TB] FAIL reset_type: got %0d want 0", bus64.imm_type_o); end
        tests_run++; if ((bus64.illegal_o !== 1'b0) || (bus64.target_o !== 64'h0) || (bus64.pc_o !== 64'h0)) begin tests_failed++; $display("[TB] FAIL reset_misc: got ill=%b tgt=%h pc=%h want all 0", bus64.illegal_o, bus64.target_o, bus64.pc_o); end
        rst = 1'b0;
        #1;
        tests_run++; if (bus64.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ready_after_reset: got %b want 1", bus64.in_ready_o); end
    endtask

    task automatic test_itype_utype();
        bus64.out_ready_i = 1'b1;
        drive64(32'hFFF00093, 64'h40);
        tests_run++; if (bus64.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL itype_pre_valid: got %b want 0", bus64.out_valid_o); end
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if (bus64.out_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL itype_valid: got %b want 1", bus64.out_valid_o); end
        tests_run++; if (bus64.imme_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("[TB] FAIL itype_imm: got %h want ffffffffffffffff", bus64.imme_o); end
        tests_run++; if (bus64.imm_type_o !== IMM_I) begin tests_failed++; $display("[TB] FAIL itype_type: got %0d want 1", bus64.imm_type_o); end
        tests_run++; if ((bus64.target_o !== 64'h0) || (bus64.pc_o !== 64'h40)) begin tests_failed++; $display("[TB] FAIL itype_tgt_pc: got tgt=%h pc=%h want 0/40", bus64.target_o, bus64.pc_o); end
        drive64(32'h800000B7, 64'h44);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if (bus64.imme_o !== 64'hFFFF_FFFF_8000_0000) begin tests_failed++; $display("[TB] FAIL lui_imm: got %h want ffffffff80000000", bus64.imme_o); end
        tests_run++; if ((bus64.imm_type_o !== IMM_U) || (bus64.target_o !== 64'h0)) begin tests_failed++; $display("[TB] FAIL lui_type_tgt: got type=%0d tgt=%h want 4/0", bus64.imm_type_o, bus64.target_o); end
        drive64(32'hFE112E23, 64'h48);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'hFFFF_FFFF_FFFF_FFFC) || (bus64.imm_type_o !== IMM_S)) begin tests_failed++; $display("[TB] FAIL store: got imm=%h type=%0d want fffffffffffffffc/2", bus64.imme_o, bus64.imm_type_o); end
        step();
        tests_run++; if (bus64.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL itype_drain: got %b want 0", bus64.out_valid_o); end
    endtask

    task automatic test_targets();
        drive64(32'h00000463, 64'h1000);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'h8) || (bus64.imm_type_o !== IMM_B)) begin tests_failed++; $display("[TB] FAIL branch_imm: got imm=%h type=%0d want 8/3", bus64.imme_o, bus64.imm_type_o); end
        tests_run++; if (bus64.target_o !== 64'h1008) begin tests_failed++; $display("[TB] FAIL branch_target: got %h want 1008", bus64.target_o); end
        drive64(32'hFFDFF06F, 64'h8000_0000);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'hFFFF_FFFF_FFFF_FFFC) || (bus64.imm_type_o !== IMM_J)) begin tests_failed++; $display("[TB] FAIL jal_imm: got imm=%h type=%0d want fffffffffffffffc/5", bus64.imme_o, bus64.imm_type_o); end
        tests_run++; if (bus64.target_o !== 64'h7FFF_FFFC) begin tests_failed++; $display("[TB] FAIL jal_target: got %h want 7ffffffc", bus64.target_o); end
        drive64(32'h00001097, 64'h100);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'h1000) || (bus64.target_o !== 64'h1100) || (bus64.imm_type_o !== IMM_U)) begin tests_failed++; $display("[TB] FAIL auipc: got imm=%h tgt=%h type=%0d want 1000/1100/4", bus64.imme_o, bus64.target_o, bus64.imm_type_o); end
        step();
    endtask

    task automatic test_shamt_csr();
        drive64(32'h03F09093, 64'h0);
        bus32.in_valid_i = 1'b1;
        bus32.inst_i     = 32'h03F09093;
        bus32.pc_i       = 32'h0;
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'd63) || (bus64.imm_type_o !== IMM_SHAMT) || (bus64.illegal_o !== 1'b0)) begin tests_failed++; $display("[TB] FAIL shamt64: got imm=%h type=%0d ill=%b want 3f/6/0", bus64.imme_o, bus64.imm_type_o, bus64.illegal_o); end
        tests_run++; if ((bus32.illegal_o !== 1'b1) || (bus32.imm_type_o !== IMM_SHAMT) || (bus32.imme_o !== 32'd63)) begin tests_failed++; $display("[TB] FAIL shamt32: got imm=%h type=%0d ill=%b want 3f/6/1", bus32.imme_o, bus32.imm_type_o, bus32.illegal_o); end
        drive64(32'h0000101B, 64'h0);
        bus32.inst_i = 32'h0000101B;
        step();
        bus64.in_valid_i = 1'b0;
        bus32.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imm_type_o !== IMM_SHAMT) || (bus64.illegal_o !== 1'b0) || (bus64.imme_o !== 64'h0)) begin tests_failed++; $display("[TB] FAIL slliw64: got imm=%h type=%0d ill=%b want 0/6/0", bus64.imme_o, bus64.imm_type_o, bus64.illegal_o); end
        tests_run++; if ((bus32.illegal_o !== 1'b1) || (bus32.imm_type_o !== IMM_NONE) || (bus32.imme_o !== 32'h0)) begin tests_failed++; $display("[TB] FAIL slliw32: got imm=%h type=%0d ill=%b want 0/0/1", bus32.imme_o, bus32.imm_type_o, bus32.illegal_o); end
        drive64(32'h300FD073, 64'h0);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.imme_o !== 64'd31) || (bus64.imm_type_o !== IMM_CSRZ)) begin tests_failed++; $display("[TB] FAIL csrz: got imm=%h type=%0d want 1f/7", bus64.imme_o, bus64.imm_type_o); end
        drive64(32'hFFFFFFFF, 64'h0);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.illegal_o !== 1'b1) || (bus64.imme_o !== 64'h0) || (bus64.imm_type_o !== IMM_NONE)) begin tests_failed++; $display("[TB] FAIL bad_opcode: got imm=%h type=%0d ill=%b want 0/0/1", bus64.imme_o, bus64.imm_type_o, bus64.illegal_o); end
        drive64(32'h00208033, 64'h0);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.illegal_o !== 1'b0) || (bus64.imm_type_o !== IMM_NONE)) begin tests_failed++; $display("[TB] FAIL rtype: got type=%0d ill=%b want 0/0", bus64.imm_type_o, bus64.illegal_o); end
        step();
    endtask

    task automatic test_back_to_back();
        bus64.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive64(32'h00000093 | ((i + 1) << 20), 64'h200 + 64'(4 * i));
            step();
            tests_run++; if ((bus64.out_valid_o !== 1'b1) || (bus64.pc_o !== 64'h200 + 64'(4 * i)) || (bus64.imme_o !== 64'(i + 1))) begin tests_failed++; $display("[TB] FAIL b2b_%0d: got v=%b pc=%h imm=%h want 1/%h/%h", i, bus64.out_valid_o, bus64.pc_o, bus64.imme_o, 64'h200 + 64'(4 * i), i + 1); end
        end
        bus64.in_valid_i = 1'b0;
        step();
        tests_run++; if (bus64.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain: got %b want 0", bus64.out_valid_o); end
    endtask

    task automatic test_backpressure();
        bus64.out_ready_i = 1'b0;
        drive64(32'h00100093, 64'h10);
        tests_run++; if (bus64.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_a: got %b want 1", bus64.in_ready_o); end
        step();
        drive64(32'h00200093, 64'h14);
        tests_run++; if ((bus64.in_ready_o !== 1'b1) || (bus64.out_valid_o !== 1'b1) || (bus64.pc_o !== 64'h10)) begin tests_failed++; $display("[TB] FAIL bp_after_a: got rdy=%b v=%b pc=%h want 1/1/10", bus64.in_ready_o, bus64.out_valid_o, bus64.pc_o); end
        step();
        drive64(32'h00300093, 64'h18);
        tests_run++; if (bus64.in_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_low: got %b want 0", bus64.in_ready_o); end
        tests_run++; if ((bus64.pc_o !== 64'h10) || (bus64.imme_o !== 64'h1)) begin tests_failed++; $display("[TB] FAIL bp_hold_a: got pc=%h imm=%h want 10/1", bus64.pc_o, bus64.imme_o); end
        step();
        tests_run++; if ((bus64.in_ready_o !== 1'b0) || (bus64.pc_o !== 64'h10) || (bus64.out_valid_o !== 1'b1)) begin tests_failed++; $display("[TB] FAIL bp_stall: got rdy=%b v=%b pc=%h want 0/1/10", bus64.in_ready_o, bus64.out_valid_o, bus64.pc_o); end
        bus64.out_ready_i = 1'b1;
        step();
        tests_run++; if ((bus64.out_valid_o !== 1'b1) || (bus64.pc_o !== 64'h14) || (bus64.imme_o !== 64'h2) || (bus64.in_ready_o !== 1'b1)) begin tests_failed++; $display("[TB] FAIL bp_out_b: got v=%b pc=%h imm=%h rdy=%b want 1/14/2/1", bus64.out_valid_o, bus64.pc_o, bus64.imme_o, bus64.in_ready_o); end
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.out_valid_o !== 1'b1) || (bus64.pc_o !== 64'h18) || (bus64.imme_o !== 64'h3)) begin tests_failed++; $display("[TB] FAIL bp_out_c: got v=%b pc=%h imm=%h want 1/18/3", bus64.out_valid_o, bus64.pc_o, bus64.imme_o); end
        step();
        tests_run++; if (bus64.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drain: got %b want 0", bus64.out_valid_o); end
    endtask

    task automatic test_flush();
        bus64.out_ready_i = 1'b0;
        drive64(32'h00500093, 64'h20);
        step();
        drive64(32'h00600093, 64'h24);
        step();
        drive64(32'h00700093, 64'h28);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.out_valid_o !== 1'b0) || (bus64.in_ready_o !== 1'b1)) begin tests_failed++; $display("[TB] FAIL flush_full: got v=%b rdy=%b want 0/1", bus64.out_valid_o, bus64.in_ready_o); end
        tests_run++; if (bus64.pc_o !== 64'h20) begin tests_failed++; $display("[TB] FAIL flush_keeps_data: got pc=%h want 20", bus64.pc_o); end
        drive64(32'h00800093, 64'h2C);
        flush = 1'b1;
        tests_run++; if (bus64.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_ready_pre: got %b want 1", bus64.in_ready_o); end
        step();
        flush = 1'b0;
        bus64.in_valid_i = 1'b0;
        bus64.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if ((bus64.out_valid_o !== 1'b0) || (bus64.pc_o !== 64'h20)) begin tests_failed++; $display("[TB] FAIL flush_discard_%0d: got v=%b pc=%h want 0/20", i, bus64.out_valid_o, bus64.pc_o); end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        bus64.out_ready_i = 1'b0;
        drive64(32'h00100093, 64'h30);
        step();
        drive64(32'h00200093, 64'h34);
        step();
        bus64.in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++; if (bus64.in_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ready: got %b want 0", bus64.in_ready_o); end
        step();
        tests_run++; if ((bus64.out_valid_o !== 1'b0) || (bus64.imme_o !== 64'h0) || (bus64.pc_o !== 64'h0) || (bus64.target_o !== 64'h0) || (bus64.imm_type_o !== IMM_NONE) || (bus64.illegal_o !== 1'b0)) begin tests_failed++; $display("[TB] FAIL mid_rst_outputs: got v=%b imm=%h pc=%h tgt=%h type=%0d ill=%b want all 0", bus64.out_valid_o, bus64.imme_o, bus64.pc_o, bus64.target_o, bus64.imm_type_o, bus64.illegal_o); end
        rst = 1'b0;
        bus64.out_ready_i = 1'b1;
        #1;
        tests_run++; if (bus64.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rst_release: got %b want 1", bus64.in_ready_o); end
        drive64(32'h00000463, 64'h1000);
        step();
        bus64.in_valid_i = 1'b0;
        tests_run++; if ((bus64.out_valid_o !== 1'b1) || (bus64.imme_o !== 64'h8) || (bus64.target_o !== 64'h1008) || (bus64.pc_o !== 64'h1000)) begin tests_failed++; $display("[TB] FAIL mid_rst_first: got v=%b imm=%h tgt=%h pc=%h want 1/8/1008/1000", bus64.out_valid_o, bus64.imme_o, bus64.target_o, bus64.pc_o); end
        step();
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        flush             = 1'b0;
        flush32           = 1'b0;
        bus64.in_valid_i  = 1'b0;
        bus64.inst_i      = 32'h0;
        bus64.pc_i        = 64'h0;
        bus64.out_ready_i = 1'b0;
        bus32.in_valid_i  = 1'b0;
        bus32.inst_i      = 32'h0;
        bus32.pc_i        = 32'h0;
        bus32.out_ready_i = 1'b1;

        test_reset();
        test_itype_utype();
        test_targets();
        test_shamt_csr();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
